// File: rtl/mha_pkg.sv
// rtl/mha_pkg.sv - shared types, format constants and lane helpers for the MHA matmul datapath
package mha_pkg;

    localparam int D_W_DEF = 16;
    localparam int FRAC_W  = 13;    // s2.13 fixed point, same format as the PE

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        FLUSH = 2'd2
    } feed_state_t;

    // LSB position of a lane inside a packed N-lane vector
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/sa_skew_lane.sv
// rtl/sa_skew_lane.sv - enable-gated shift chain of {vld, data} for one skewed lane
module sa_skew_lane
    import mha_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int D_W   = D_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           head_vld,
    input  logic [D_W-1:0] head_data,
    output logic           tail_vld,
    output logic [D_W-1:0] tail_data
);

    logic [DEPTH-1:0] vld_q;
    logic [D_W-1:0]   data_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < DEPTH; j++) begin
                vld_q[j]  <= 1'b0;
                data_q[j] <= '0;
            end
        end else if (en) begin
            vld_q[0]  <= head_vld;
            data_q[0] <= head_data;
            for (int j = 1; j < DEPTH; j++) begin
                vld_q[j]  <= vld_q[j-1];
                data_q[j] <= data_q[j-1];
            end
        end
    end

    assign tail_vld  = vld_q[DEPTH-1];
    assign tail_data = data_q[DEPTH-1];

endmodule

// File: rtl/sa_skew_feeder.sv
// rtl/sa_skew_feeder.sv - diagonal skew feeder for one systolic-array edge; SA_FEEDER_STALL_CNT_EN adds O_STALL_CNT
module sa_skew_feeder
    import mha_pkg::*;
#(
    parameter int D_W   = D_W_DEF,
    parameter int N     = 4,
    parameter int K_MAX = 64,
    parameter int CNT_W = $clog2(K_MAX + 1)
) (
    input  logic             I_CLK,
    input  logic             I_SYNC_RST,
    input  logic             I_START,
    input  logic [CNT_W-1:0] I_K,
    input  logic             I_EN,
    input  logic             I_VLD,
    input  logic [N*D_W-1:0] I_X,
    output logic             O_RDY,
    output logic [N-1:0]     O_VLD,
    output logic [N*D_W-1:0] O_X,
    output logic             O_BUSY,
    output logic             O_DONE
`ifdef SA_FEEDER_STALL_CNT_EN
    ,
    output logic [31:0]      O_STALL_CNT
`endif
);

    localparam int FL_W = (N > 1) ? $clog2(N) : 1;

    feed_state_t      state;
    logic [CNT_W-1:0] k_q;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] k_sat;
    logic [FL_W-1:0]  flush_cnt;
    logic             in_feed;
    logic             accept;

    assign in_feed = (state == FEED);
    assign O_RDY   = in_feed & I_EN;
    assign accept  = I_VLD & O_RDY;
    assign O_BUSY  = (state != IDLE);
    assign k_sat   = (I_K > CNT_W'(K_MAX)) ? CNT_W'(K_MAX) : I_K;

    always_ff @(posedge I_CLK) begin
        if (I_SYNC_RST) begin
            state     <= IDLE;
            k_q       <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            O_DONE    <= 1'b0;
        end else begin
            O_DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (I_START) begin
                        if (k_sat != '0) begin
                            k_q      <= k_sat;
                            beat_cnt <= '0;
                            state    <= FEED;
                        end else begin
                            O_DONE <= 1'b1;
                        end
                    end
                end
                FEED: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if ((beat_cnt + CNT_W'(1)) == k_q) begin
                            flush_cnt <= '0;
                            state     <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    // N enabled steps push the last beat out of the deepest lane
                    if (I_EN) begin
                        flush_cnt <= flush_cnt + FL_W'(1);
                        if (flush_cnt == FL_W'(N - 1)) begin
                            state  <= IDLE;
                            O_DONE <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        sa_skew_lane #(
            .DEPTH (i + 1),
            .D_W   (D_W)
        ) u_lane (
            .clk       (I_CLK),
            .rst       (I_SYNC_RST),
            .en        (I_EN),
            .head_vld  (accept),
            .head_data (in_feed ? I_X[lane_lsb(i, D_W) +: D_W] : '0),
            .tail_vld  (O_VLD[i]),
            .tail_data (O_X[lane_lsb(i, D_W) +: D_W])
        );
    end

`ifdef SA_FEEDER_STALL_CNT_EN
    always_ff @(posedge I_CLK) begin
        if (I_SYNC_RST) begin
            O_STALL_CNT <= '0;
        end else if ((state == IDLE) && I_START) begin
            O_STALL_CNT <= '0;
        end else if (in_feed && I_EN && !I_VLD && (O_STALL_CNT != '1)) begin
            O_STALL_CNT <= O_STALL_CNT + 32'd1;
        end
    end
`endif

endmodule
